// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM state encoding and access legality for the load/store unit.
package riscv_lsu_defs;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } lsu_state_e;
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic half_ok, word_ok;
    half_ok = !off[0];
    word_ok = off == 2'b00;
    return we ? !(f3 == F3_B || (f3 == F3_H && half_ok) || (f3 == F3_W && word_ok))
              : !(f3 == F3_B || f3 == F3_BU || ((f3 == F3_H || f3 == F3_HU) && half_ok) ||
                  (f3 == F3_W && word_ok));
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and word-memory signals of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_W = 5);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_unit_extract.sv
// lsu_extract: little-endian byte/half lane select with sign or zero extension for loads.
module lsu_extract
  import riscv_lsu_defs::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = 8'(rd >> {off, 3'b000});
    h    = off[1] ? rd[31:16] : rd[15:0];
    data = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_BU ? {24'h0, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_HU ? {16'h0, h} : rd;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte-addressed RV32I loads/stores into word accesses, using read-modify-write for SB/SH.
module load_store_unit
  import riscv_lsu_defs::*;
#(
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  lsu_state_e  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        err;
  logic [31:0] ext, mask, merged;
  lsu_extract u_extract (
    .rd    (bus.mem_rd),
    .off   (off_q),
    .funct3(f3_q),
    .data  (ext)
  );
  assign bus.req_ready = state == S_IDLE;
  // mem_wd still holds the store data until CAPTURE, so the merge reads the new lanes from it
  always_comb begin
    err    = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    mask   = (f3_q == F3_H ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
    merged = (bus.mem_rd & ~mask) | ((bus.mem_wd << {off_q, 3'b000}) & mask);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      off_q          <= 2'b00;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.resp_err   <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_a      <= '0;
      bus.mem_wd     <= 32'h0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          we_q       <= bus.req_we;
          f3_q       <= bus.req_funct3;
          off_q      <= bus.req_addr[1:0];
          bus.mem_a  <= bus.req_addr[ADDR_W+1:2];
          bus.mem_wd <= bus.req_wdata;
          if (err) begin
            state          <= S_DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'h0;
          end else if (bus.req_we && bus.req_funct3 == F3_W) begin
            state      <= S_WRITE;
            bus.mem_we <= 1'b1;
          end else begin
            state <= S_READ;
          end
        end
        S_READ: state <= S_CAPTURE;
        S_CAPTURE: if (we_q) begin
          bus.mem_wd <= merged;
          bus.mem_we <= 1'b1;
          state      <= S_WRITE;
        end else begin
          bus.resp_rdata <= ext;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= S_DONE;
        end
        S_WRITE: begin
          bus.mem_we     <= 1'b0;
          bus.resp_rdata <= 32'h0;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= S_DONE;
        end
        S_DONE: begin
          bus.resp_valid <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors against a synchronous word memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int checks = 0;
  int errors = 0;
  int wcnt = 0;
  int acc = 0;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  a_c1;
  logic [31:0] mem [32];

  load_store_unit_if #(.ADDR_W(5)) bus ();
  load_store_unit #(.ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (bus.mem_we && !rst) begin
      mem[bus.mem_a] <= bus.mem_wd;
    end
    bus.mem_rd <= mem[bus.mem_a];
  end

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wcnt = wcnt + 1;
      wa = bus.mem_a;
      wd = bus.mem_wd;
    end
    if (bus.req_valid && bus.req_ready) acc = acc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic hold, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_w);
    int w0, lat, n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    w0 = wcnt;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    a_c1 = bus.mem_a;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      if (bus.resp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_wcnt"}, wcnt - w0, exp_w);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t loads [5] = '{
    '{"lb",  3'b000, 32'h0B, 32'hFFFF_FFDE},
    '{"lbu", 3'b100, 32'h0B, 32'h0000_00DE},
    '{"lh",  3'b001, 32'h0A, 32'hFFFF_DEAD},
    '{"lhu", 3'b101, 32'h0A, 32'h0000_DEAD},
    '{"lw",  3'b010, 32'h08, 32'hDEAD_BEEF}
  };

  initial begin
    int a0, w0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_a", {27'd0, bus.mem_a}, 32'd0);
    check("rst_mem_wd", bus.mem_wd, 32'h0);

    txn("sw", 1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 1'b0, 2, 32'h0, 1'b0, 1);
    check("sw_wa", {27'd0, wa}, 32'd2);
    check("sw_wd", wd, 32'hDEAD_BEEF);

    foreach (loads[i])
      txn(loads[i].tag, 1'b0, loads[i].f3, loads[i].addr, 32'h0, 1'b0, 3, loads[i].exp, 1'b0, 0);

    txn("sb", 1'b1, 3'b000, 32'h09, 32'h0000_0055, 1'b0, 4, 32'h0, 1'b0, 1);
    check("sb_wd", wd, 32'hDEAD_55EF);
    check("sb_wa", {27'd0, wa}, 32'd2);
    txn("sh", 1'b1, 3'b001, 32'h0E, 32'h1234_ABCD, 1'b0, 4, 32'h0, 1'b0, 1);
    check("sh_wd", wd, 32'hABCD_0003);
    check("sh_mem3", mem[3], 32'hABCD_0003);
    txn("lw_after_sb", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 3, 32'hDEAD_55EF, 1'b0, 0);

    txn("lw_mis", 1'b0, 3'b010, 32'h06, 32'h0, 1'b0, 1, 32'h0, 1'b1, 0);
    txn("sh_mis", 1'b1, 3'b001, 32'h03, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b1, 0);
    txn("ld_f3_011", 1'b0, 3'b011, 32'h00, 32'h0, 1'b0, 1, 32'h0, 1'b1, 0);
    txn("st_f3_100", 1'b1, 3'b100, 32'h00, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b1, 0);
    check("mis_word0", mem[0], 32'h1000_0000);
    check("mis_word1", mem[1], 32'h1000_0001);

    a0 = acc;
    txn("lw_wrap", 1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 3, 32'h1000_0000, 1'b0, 0);
    check("wrap_mem_a", {27'd0, a_c1}, 32'd0);
    check("hold_accepts", acc - a0, 1);

    @(negedge clk);
    w0 = wcnt;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h11;
    bus.req_wdata = 32'h0000_0077;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mid_mem_a", {27'd0, bus.mem_a}, 32'd0);
    check("rst_mid_mem_wd", bus.mem_wd, 32'h0);
    check("rst_mid_rdata", bus.resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mid_wcnt", wcnt - w0, 0);
    check("rst_mid_word4", mem[4], 32'h1000_0004);
    txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 3, 32'h1000_0004, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
